// File: rtl/h1_scheduler_pkg.sv
// rtl/h1_scheduler_pkg.sv - shared types and default sizes for the H1 scheduler
package h1_scheduler_pkg;

   localparam int DEF_NCH = 4;
   localparam int DEF_W   = 16;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

endpackage

// File: rtl/h1_core.sv
// rtl/h1_core.sv - combinational H1 kernel y = 2*h1 - 4*h2 (mod 2^W)
//
// Ports:
//   h1 : previous sample x[n-1]
//   h2 : sample before that, x[n-2]
//   y  : 2*h1 - 4*h2, wrapped to W bits, no saturation
module h1_core
   import h1_scheduler_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic [W-1:0] h1,
   input  logic [W-1:0] h2,
   output logic [W-1:0] y
);

   // Shifts drop the top bits, which is exactly the modulo-2^W behaviour wanted.
   assign y = {h1[W-2:0], 1'b0} - {h2[W-3:0], 2'b00};

endmodule

// File: rtl/h1_scheduler.sv
// rtl/h1_scheduler.sv - round-robin multi-channel scheduler around one shared H1 datapath
//
// Ports:
//   CLK       : clock, rising edge
//   reset     : asynchronous active-low reset
//   clear     : request to zero every channel history (takes NCH cycles)
//   in_valid  : per-channel sample valid
//   in_data   : channel i sample at [i*W +: W]
//   in_ready  : one-hot grant, combinational
//   out_valid : out_data/out_chan hold a result
//   out_ready : downstream accept
//   out_data  : H1 result of the accepted sample
//   out_chan  : channel that produced out_data
//   busy      : high while histories are being flushed
module h1_scheduler
   import h1_scheduler_pkg::*;
#(
   parameter int NCH = DEF_NCH,
   parameter int W   = DEF_W
) (
   input  logic                    CLK,
   input  logic                    reset,
   input  logic                    clear,
   input  logic [NCH-1:0]          in_valid,
   input  logic [NCH*W-1:0]        in_data,
   output logic [NCH-1:0]          in_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [W-1:0]            out_data,
   output logic [$clog2(NCH)-1:0]  out_chan,
   output logic                    busy
);

   localparam int CW = $clog2(NCH);

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   rr_ptr;
   logic [CW-1:0]   flush_idx;
   logic [CW-1:0]   cand;
   logic [CW-1:0]   grant_idx;
   logic            grant_any;
   logic            grant_ok;
   logic            take;
   logic [W-1:0]    sel_x;
   logic [W-1:0]    core_y;
   logic [W-1:0]    h1_mem [NCH];
   logic [W-1:0]    h2_mem [NCH];

   // A grant needs RUN, no clear this cycle (clear wins), and a free or draining output slot.
   assign grant_ok = reset && (state == RUN) && !clear && (!out_valid || out_ready);

   // Round-robin search starting at rr_ptr; index arithmetic wraps because NCH is a power of two.
   always_comb begin
      cand      = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NCH; k++) begin
         cand = rr_ptr + CW'(k);
         if (!grant_any && in_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign take  = grant_ok && grant_any;
   assign sel_x = in_data[grant_idx*W +: W];

   always_comb begin
      in_ready = '0;
      if (take) begin
         in_ready[grant_idx] = 1'b1;
      end
   end

   h1_core #(.W(W)) u_core (
      .h1 (h1_mem[grant_idx]),
      .h2 (h2_mem[grant_idx]),
      .y  (core_y)
   );

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         RUN: begin
            if (clear) begin
               state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            busy = 1'b1;
            if (flush_idx == CW'(NCH - 1)) begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         rr_ptr    <= '0;
         flush_idx <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         for (int i = 0; i < NCH; i++) begin
            h1_mem[i] <= '0;
            h2_mem[i] <= '0;
         end
      end else begin
         if (take) begin
            out_valid         <= 1'b1;
            out_data          <= core_y;
            out_chan          <= grant_idx;
            rr_ptr            <= grant_idx + CW'(1);
            h2_mem[grant_idx] <= h1_mem[grant_idx];
            h1_mem[grant_idx] <= sel_x;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         // Grants never happen in FLUSH, so these writes never collide with the ones above.
         if (state == FLUSH) begin
            h1_mem[flush_idx] <= '0;
            h2_mem[flush_idx] <= '0;
            flush_idx         <= flush_idx + CW'(1);
         end else begin
            flush_idx <= '0;
         end
      end
   end

endmodule

// File: doc/h1_scheduler.md
H1_SCHEDULER -- requirements
Module: h1_scheduler

Interface
REQ-001 Parameter NCH, default 4, number of requesting channels (power of two, 2..8).
REQ-002 Parameter W, default 16, sample width, two's complement.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 clear  input  1  synchronous request to zero all channel histories.
REQ-006 in_valid  input  NCH  per-channel sample valid.
REQ-007 in_data  input  NCH*W  channel i sample at bits [i*W +: W].
REQ-008 in_ready  output  NCH  one-hot grant; channel i accepted when in_valid[i] and in_ready[i] are both high.
REQ-009 out_valid  output  1  out_data and out_chan are valid.
REQ-010 out_ready  input  1  downstream accept.
REQ-011 out_data  output  W  H1 result for the accepted sample.
REQ-012 out_chan  output  log2(NCH)  channel index of out_data.
REQ-013 busy  output  1  high in FLUSH state.

Function
REQ-014 Per channel i the block SHALL hold history h1[i] = x[n-1] and h2[i] = x[n-2], W bits each, in a single shared H1 datapath.
REQ-015 On acceptance of x from channel i, result SHALL be y = 2*h1[i] - 4*h2[i], computed modulo 2^W with no saturation; then h2[i] <= h1[i] and h1[i] <= x, both updated in the same cycle.
REQ-016 Latency: y SHALL appear on out_data with out_valid=1 on the cycle after acceptance, registered.
REQ-017 Arbitration SHALL be round-robin: search starts at pointer p; after a grant to channel i, p <= (i+1) mod NCH; p SHALL be 0 after reset.
REQ-018 in_ready SHALL be combinational from in_valid, p and state, and SHALL have at most one bit set.
REQ-019 A grant SHALL be issued only when state = RUN and the output slot is free or draining (out_valid=0 or out_ready=1); this gives one sample per cycle under no backpressure.
REQ-020 While out_valid=1 and out_ready=0: out_data and out_chan SHALL hold stable, in_ready SHALL be 0, and no history SHALL change.
REQ-021 States: RUN, FLUSH. RUN->FLUSH when clear=1; FLUSH zeroes one channel's h1/h2 per cycle, index 0..NCH-1, then returns to RUN.
REQ-022 In FLUSH: in_ready=0 and busy=1; a pending output SHALL still complete the out_valid/out_ready handshake.
REQ-023 clear asserted during FLUSH SHALL be ignored; clear in the same cycle as a grant SHALL block that grant (clear wins).
REQ-024 Channels not granted SHALL keep their history unchanged.

Reset
REQ-025 With reset=0, asynchronously: all h1/h2=0, p=0, state=RUN, out_valid=0, out_data=0, out_chan=0, busy=0.
REQ-026 Reset asserted mid-transfer SHALL discard any pending output; in_ready SHALL be 0 while reset=0.

Structure
REQ-027 A shared package SHALL hold the state enum (RUN, FLUSH) and the default NCH and W constants.
REQ-028 The arithmetic SHALL be one sub-module, h1_core, that is purely combinational: (h1, h2) -> 2*h1 - 4*h2, W bits. The arbiter, history bank and FSM SHALL stay in h1_scheduler.

Verification
REQ-029 Channel 0 only, out_ready=1, sends 1, 2, 3, 0 -> out_data 0x0000, 0x0002, 0x0000, 0xFFFE, all with out_chan=0, one cycle after each acceptance.
REQ-030 All four channels valid continuously, out_ready=1 -> grants in order 0,1,2,3,0,...; one output per cycle; each channel's results match its own history.
REQ-031 Channel 1 sends 0x4000 then 0x0000 -> second result is 0x8000, showing wrap with no saturation.
REQ-032 out_ready held 0 for 5 cycles with all channels valid -> out_data and out_chan stable, in_ready=0, no history change; release gives the next grant in the same cycle.
REQ-033 Load histories, pulse clear -> busy=1 for NCH cycles with no grants; next sample on any channel yields 0x0000.
REQ-034 reset pulsed low while out_valid=1 -> out_valid drops immediately; afterwards p=0 and histories are zero (first result per channel is 0x0000).
